// File: rtl/jtframe_pocket_pkg.sv
// Shared types and helpers for the Pocket download serializer.
package jtframe_pocket_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StWait
  } dwnld_state_e;

  localparam logic [7:0] CtrlPageDefault = 8'hF8;

  function automatic int unsigned bytes_per_word(input int unsigned wordw);
    return wordw / 8;
  endfunction

  // Width of the byte-within-word index; at least 1 so counters stay legal.
  function automatic int unsigned byte_sel_bits(input int unsigned wordw);
    int unsigned b;
    b = $clog2(wordw / 8);
    return (b == 0) ? 1 : b;
  endfunction

endpackage

// File: rtl/jtframe_pocket_dwnld_if.sv
// Bridge-write and ioctl signal bundle of the Pocket download serializer.
interface jtframe_pocket_dwnld_if #(
  parameter int unsigned WORDW = 32,
  parameter int unsigned AW    = 25
);
  logic             wr;
  logic [31:0]      wr_addr;
  logic [WORDW-1:0] wr_data;
  logic [7:0]       wr_idx;
  logic             ds_done;
  logic             prog_rdy;
  logic             wr_full;
  logic [AW-1:0]    ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic             ioctl_wr;
  logic [7:0]       ioctl_index;
  logic             downloading;
  logic             overflow;

  modport master (
    output wr, wr_addr, wr_data, wr_idx, ds_done, prog_rdy,
    input  wr_full, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, overflow
  );

  modport slave (
    input  wr, wr_addr, wr_data, wr_idx, ds_done, prog_rdy,
    output wr_full, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, overflow
  );
endinterface

// File: rtl/jtframe_pocket_wfifo.sv
// Small synchronous FIFO; pushes while full are dropped even if a pop coincides.
module jtframe_pocket_wfifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/jtframe_pocket_dwnld.sv
// Pocket download serializer: queues bridge words and emits them as byte-wide ioctl writes.
module jtframe_pocket_dwnld
  import jtframe_pocket_pkg::*;
#(
  parameter int unsigned WORDW     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 25,
  parameter int unsigned LITTLE    = 0,
  parameter int unsigned WAIT_RDY  = 1,
  parameter logic [7:0]  CTRL_PAGE = CtrlPageDefault
) (
  input logic                  clk,
  input logic                  rst,
  jtframe_pocket_dwnld_if.slave bus
);
  localparam int unsigned B  = bytes_per_word(WORDW);
  localparam int unsigned KW = byte_sel_bits(WORDW);
  localparam int unsigned EW = AW + WORDW + 8;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] AlignMask = ~(AW'(B - 1));

  dwnld_state_e     state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [WORDW-1:0] shift_q, shift_d, shifted;
  logic [7:0]       idx_q, idx_d;
  logic [KW-1:0]    k_q, k_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [7:0]       dout_q, dout_d, cur_byte;
  logic [7:0]       index_q, index_d;
  logic             dl_q, dl_d;
  logic             ovf_q, ovf_d;

  logic             ctrl_hit, accept, pop, last;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [EW-1:0]    fifo_din, fifo_dout;

  assign ctrl_hit = (bus.wr_addr[31:24] == CTRL_PAGE);
  assign accept   = bus.wr && !ctrl_hit && !fifo_full;
  assign fifo_din = {bus.wr_addr[AW-1:0] & AlignMask, bus.wr_data, bus.wr_idx};

  jtframe_pocket_wfifo #(
    .Width (EW),
    .Depth (DEPTH)
  ) u_wfifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (accept),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The byte on the wire is always at the leading end of the shift register.
  assign cur_byte = (LITTLE != 0) ? shift_q[7:0] : shift_q[WORDW-1 -: 8];
  assign shifted  = (LITTLE != 0) ? (shift_q >> 8) : (shift_q << 8);
  assign last     = (k_q == KW'(B - 1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    k_d     = k_q;
    pop     = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    dout_d  = dout_q;
    index_d = index_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop                     = 1'b1;
          {base_d, shift_d, idx_d} = fifo_dout;
          k_d                     = '0;
          state_d                 = StEmit;
        end
      end
      StEmit: begin
        wr_d    = 1'b1;
        addr_d  = base_q | AW'(k_q);
        dout_d  = cur_byte;
        index_d = idx_q;
        if (last) begin
          state_d = StIdle;
        end else if (WAIT_RDY != 0) begin
          state_d = StWait;
        end else begin
          k_d     = k_q + KW'(1);
          shift_d = shifted;
        end
      end
      StWait: begin
        // Only prog_rdy seen here counts; a pulse during StEmit is ignored.
        if (bus.prog_rdy) begin
          k_d     = k_q + KW'(1);
          shift_d = shifted;
          state_d = StEmit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear waits for the FSM to drain; a new index-0 word wins over the clear.
  always_comb begin
    dl_d  = dl_q;
    ovf_d = ovf_q;
    if (bus.ds_done && fifo_empty && (state_q == StIdle)) dl_d = 1'b0;
    if (accept && (bus.wr_idx == 8'd0)) dl_d = 1'b1;
    if (bus.wr && !ctrl_hit && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      index_q <= '0;
      dl_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      index_q <= index_d;
      dl_q    <= dl_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.wr_full     = (fifo_count == CW'(DEPTH));
  assign bus.ioctl_wr    = wr_q;
  assign bus.ioctl_addr  = addr_q;
  assign bus.ioctl_dout  = dout_q;
  assign bus.ioctl_index = index_q;
  assign bus.downloading = dl_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Bench for jtframe_pocket_dwnld: three configurations share one stimulus stream.
module tb_jtframe_pocket_dwnld;
  localparam int unsigned AW = 25;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    dout;
    logic [7:0]    idx;
  } exp_t;

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [7:0]    idx;
    bit            ctrl;
    logic [AW-1:0] base;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_idx = '0;
  logic        ds_done = 1'b0;
  logic        prog_p = 1'b0;
  logic        prog_level = 1'b0;
  bit          prog_pulse_en = 1'b0;
  logic        prog_rdy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c_last = -10;
  int c_cnt = 0;

  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign prog_rdy = prog_p | prog_level;

  // a: MSB first, no flow control; b: LSB first, no flow control; c: MSB first, prog_rdy paced
  jtframe_pocket_dwnld_if #(.WORDW(32), .AW(AW)) if_a ();
  jtframe_pocket_dwnld_if #(.WORDW(32), .AW(AW)) if_b ();
  jtframe_pocket_dwnld_if #(.WORDW(32), .AW(AW)) if_c ();

  assign if_a.wr = wr;            assign if_b.wr = wr;            assign if_c.wr = wr;
  assign if_a.wr_addr = wr_addr;  assign if_b.wr_addr = wr_addr;  assign if_c.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data;  assign if_b.wr_data = wr_data;  assign if_c.wr_data = wr_data;
  assign if_a.wr_idx = wr_idx;    assign if_b.wr_idx = wr_idx;    assign if_c.wr_idx = wr_idx;
  assign if_a.ds_done = ds_done;  assign if_b.ds_done = ds_done;  assign if_c.ds_done = ds_done;
  assign if_a.prog_rdy = prog_rdy; assign if_b.prog_rdy = prog_rdy; assign if_c.prog_rdy = prog_rdy;

  jtframe_pocket_dwnld #(.WORDW(32), .DEPTH(4), .AW(AW), .LITTLE(0), .WAIT_RDY(0),
    .CTRL_PAGE(8'hF8)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  jtframe_pocket_dwnld #(.WORDW(32), .DEPTH(4), .AW(AW), .LITTLE(1), .WAIT_RDY(0),
    .CTRL_PAGE(8'hF8)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  jtframe_pocket_dwnld #(.WORDW(32), .DEPTH(4), .AW(AW), .LITTLE(0), .WAIT_RDY(1),
    .CTRL_PAGE(8'hF8)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input bit little, input int k);
    return little ? d[8*k +: 8] : d[31-8*k -: 8];
  endfunction

  task automatic push_exp(input logic [AW-1:0] base, input logic [31:0] d, input logic [7:0] idx,
                          input int na, input int nb, input int nc);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr = base | AW'(k);
      e.idx  = idx;
      e.dout = byte_of(d, 1'b0, k);
      if (k < na) qa.push_back(e);
      if (k < nc) qc.push_back(e);
      e.dout = byte_of(d, 1'b1, k);
      if (k < nb) qb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] addr, input logic [AW-1:0] base, input logic [31:0] d,
                      input logic [7:0] idx, input int na, input int nb, input int nc);
    wr = 1'b1;
    wr_addr = addr;
    wr_data = d;
    wr_idx = idx;
    push_exp(base, d, idx, na, nb, nc);
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Scoreboard: every strobe must match the oldest expected byte of its instance.
  always @(negedge clk) begin
    exp_t e;
    if (if_a.ioctl_wr) begin
      check("a_strobe_expected", 64'(qa.size() != 0), 64'(1));
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_byte", 64'({if_a.ioctl_addr, if_a.ioctl_dout, if_a.ioctl_index}), 64'(e));
      end
    end
    if (if_b.ioctl_wr) begin
      check("b_strobe_expected", 64'(qb.size() != 0), 64'(1));
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_byte", 64'({if_b.ioctl_addr, if_b.ioctl_dout, if_b.ioctl_index}), 64'(e));
      end
    end
    if (if_c.ioctl_wr) begin
      check("c_strobe_expected", 64'(qc.size() != 0), 64'(1));
      if (qc.size() != 0) begin
        e = qc.pop_front();
        check("c_byte", 64'({if_c.ioctl_addr, if_c.ioctl_dout, if_c.ioctl_index}), 64'(e));
      end
      check("c_no_back_to_back", 64'((cyc - c_last) > 1), 64'(1));
      c_last <= cyc;
      c_cnt <= c_cnt + 1;
    end
  end

  // prog_rdy pulse sampled on the third edge after each strobe of instance c.
  initial begin
    forever begin
      @(negedge clk);
      if (prog_pulse_en && if_c.ioctl_wr) begin
        @(negedge clk);
        @(negedge clk);
        prog_p = 1'b1;
        @(negedge clk);
        prog_p = 1'b0;
      end
    end
  end

  initial begin
    vec_t vecs[5];
    int   c_off[$];
    int   c_snap;

    vecs[0] = '{32'h0000_0200, 32'hA1B2_C3D4, 8'h01, 1'b0, 25'h000_0200};
    vecs[1] = '{32'h0200_0107, 32'hDEAD_BEEF, 8'h03, 1'b0, 25'h000_0104};
    vecs[2] = '{32'hF800_0040, 32'h5555_5555, 8'h00, 1'b1, 25'h000_0000};
    vecs[3] = '{32'h01FF_FFFC, 32'h0F1E_2D3C, 8'hFF, 1'b0, 25'h1FF_FFFC};
    vecs[4] = '{32'hF700_0010, 32'h00FF_00FF, 8'h07, 1'b0, 25'h100_0010};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a", 64'({if_a.ioctl_wr, if_a.ioctl_addr, if_a.ioctl_dout, if_a.ioctl_index,
                        if_a.downloading, if_a.overflow, if_a.wr_full}), 64'(0));
    check("rst_b", 64'({if_b.ioctl_wr, if_b.ioctl_addr, if_b.ioctl_dout, if_b.ioctl_index,
                        if_b.downloading, if_b.overflow, if_b.wr_full}), 64'(0));
    check("rst_c", 64'({if_c.ioctl_wr, if_c.ioctl_addr, if_c.ioctl_dout, if_c.ioctl_index,
                        if_c.downloading, if_c.overflow, if_c.wr_full}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic word: latency, strobe window, prog_rdy pacing
    prog_pulse_en = 1'b1;
    send(32'h0000_0100, 25'h100, 32'h1122_3344, 8'h00, 4, 4, 4);
    check("dl_set_a", 64'(if_a.downloading), 64'(1));
    check("dl_set_c", 64'(if_c.downloading), 64'(1));
    for (int off = 0; off < 20; off++) begin
      if (off > 0) @(negedge clk);
      check("a_strobe_window", 64'(if_a.ioctl_wr), 64'(off >= 2 && off <= 5));
      check("b_strobe_window", 64'(if_b.ioctl_wr), 64'(off >= 2 && off <= 5));
      if (if_c.ioctl_wr) c_off.push_back(off);
    end
    check("c_strobe_count", 64'(c_off.size()), 64'(4));
    for (int i = 0; i < c_off.size(); i++) check("c_strobe_off", 64'(c_off[i]), 64'(2 + 4 * i));

    // Table of words, including a control-page write that must vanish
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].addr, vecs[i].base, vecs[i].data, vecs[i].idx,
           vecs[i].ctrl ? 0 : 4, vecs[i].ctrl ? 0 : 4, vecs[i].ctrl ? 0 : 4);
      repeat (20) @(negedge clk);
    end
    check("tbl_qa_empty", 64'(qa.size()), 64'(0));
    check("tbl_qb_empty", 64'(qb.size()), 64'(0));
    check("tbl_qc_empty", 64'(qc.size()), 64'(0));

    // Overflow: c parked in WAIT, then five back-to-back writes
    prog_pulse_en = 1'b0;
    repeat (4) @(negedge clk);
    send(32'h0000_0300, 25'h300, 32'hCAFE_F00D, 8'h02, 4, 4, 4);
    repeat (8) @(negedge clk);
    check("c_parked_not_full", 64'(if_c.wr_full), 64'(0));
    c_snap = c_cnt;
    send(32'h0000_0400, 25'h400, 32'h0102_0304, 8'h02, 4, 4, 4);
    send(32'h0000_0404, 25'h404, 32'h0506_0708, 8'h02, 4, 4, 4);
    send(32'h0000_0408, 25'h408, 32'h090A_0B0C, 8'h02, 4, 4, 4);
    send(32'h0000_040C, 25'h40C, 32'h0D0E_0F10, 8'h02, 4, 4, 4);
    check("c_full_after_4", 64'(if_c.wr_full), 64'(1));
    check("a_not_full_after_4", 64'(if_a.wr_full), 64'(0));
    send(32'h0000_0410, 25'h410, 32'h1112_1314, 8'h02, 4, 4, 0);
    check("c_overflow", 64'(if_c.overflow), 64'(1));
    check("a_no_overflow", 64'(if_a.overflow), 64'(0));
    check("a_full_after_5", 64'(if_a.wr_full), 64'(1));
    repeat (6) @(negedge clk);
    check("c_held_no_strobe", 64'(c_cnt - c_snap), 64'(0));
    prog_level = 1'b1;
    repeat (60) @(negedge clk);
    check("c_bytes_after_release", 64'(c_cnt - c_snap), 64'(19));
    check("ovf_qa_empty", 64'(qa.size()), 64'(0));
    check("ovf_qb_empty", 64'(qb.size()), 64'(0));
    check("ovf_qc_empty", 64'(qc.size()), 64'(0));
    check("c_overflow_sticky", 64'(if_c.overflow), 64'(1));

    // ds_done with two words queued
    send(32'h0000_0500, 25'h500, 32'h2122_2324, 8'h05, 4, 4, 4);
    send(32'h0000_0504, 25'h504, 32'h2526_2728, 8'h05, 4, 4, 4);
    ds_done = 1'b1;
    for (int off = 2; off < 20; off++) begin
      @(negedge clk);
      check("a_dl_until_drained", 64'(if_a.downloading), 64'(off <= 10));
      check("b_dl_until_drained", 64'(if_b.downloading), 64'(off <= 10));
      check("c_dl_until_drained", 64'(if_c.downloading), 64'(off <= 16));
    end

    // Control-page write leaves downloading alone
    send(32'hF800_0000, 25'h0, 32'h1234_5678, 8'h00, 0, 0, 0);
    ds_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("ctrl_a_dl", 64'(if_a.downloading), 64'(0));
      check("ctrl_a_full", 64'(if_a.wr_full), 64'(0));
      @(negedge clk);
    end

    // Reset mid-word
    send(32'h0000_0600, 25'h600, 32'h89AB_CDEF, 8'h00, 2, 2, 1);
    check("mid_a_dl", 64'(if_a.downloading), 64'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_a_wr", 64'(if_a.ioctl_wr), 64'(0));
    check("rst_mid_a_dl", 64'(if_a.downloading), 64'(0));
    check("rst_mid_c_ovf", 64'(if_c.overflow), 64'(0));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("end_qa_empty", 64'(qa.size()), 64'(0));
    check("end_qb_empty", 64'(qb.size()), 64'(0));
    check("end_qc_empty", 64'(qc.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
